// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_pkg
// Brief   : Shared types and constants for the I/D memory port arbiter.
// Revision: 1.0
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam logic GNT_I      = 1'b0;
    localparam logic GNT_D      = 1'b1;
    localparam int   WAIT_CNT_W = 4;

    typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;

    function automatic logic is_store(input logic [3:0] wstrb);
        return |wstrb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_grant.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_grant
// Brief   : One-hot grant select between fetch and data requesters.
//           MEM_ARB_RR_EN selects round-robin on ties, else D over I.
// Revision: 1.0
// ============================================================================
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic ireq_valid_i,
    input  logic dreq_valid_i,
`ifdef MEM_ARB_RR_EN
    input  logic last_grant_i,
`endif
    output logic gnt_i_o,
    output logic gnt_d_o
);

    logic w_pick_d;

    always_comb begin
        w_pick_d = 1'b0;
`ifdef MEM_ARB_RR_EN
        // On a tie the side that did not win last time is served.
        w_pick_d = dreq_valid_i & (~ireq_valid_i | (last_grant_i == GNT_I));
`else
        w_pick_d = dreq_valid_i;
`endif
    end

    assign gnt_d_o = w_pick_d;
    assign gnt_i_o = ireq_valid_i & ~w_pick_d;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter
// Brief   : Shares one 32-bit memory port between fetch and load/store with a
//           single outstanding transaction. Optional macro: MEM_ARB_RR_EN.
// Revision: 1.0
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned pMemLatency = 32'd1
) (
    input  logic        iwClk,
    input  logic        iwnRst,
    input  logic        iwIReqValid,
    output logic        owIReqReady,
    input  logic [31:0] iwIAddr,
    output logic        owIRespValid,
    output logic [31:0] owIRespData,
    input  logic        iwDReqValid,
    output logic        owDReqReady,
    input  logic [31:0] iwDAddr,
    input  logic [31:0] iwDWdata,
    input  logic [3:0]  iwDWstrb,
    output logic        owDRespValid,
    output logic [31:0] owDRespData,
    output logic        owMemEn,
    output logic [31:0] owMemAddr,
    output logic [31:0] owMemWdata,
    output logic [3:0]  owMemWstrb,
    input  logic [31:0] iwMemRdata
);

    localparam wait_cnt_t WAIT_LOAD = wait_cnt_t'(pMemLatency - 32'd1);

    generate
        if (pMemLatency < 32'd1 || pMemLatency > 32'd15) begin : g_lat_check
            $error("pMemLatency must be in 1..15");
        end
    endgenerate

    arb_state_e  r_state_q;
    logic        r_gid_q;
    logic        r_store_q;
    wait_cnt_t   r_wait_cnt_q;
    logic        r_mem_en_q;
    logic [31:0] r_addr_q;
    logic [31:0] r_wdata_q;
    logic [3:0]  r_wstrb_q;
    logic        r_irv_q;
    logic        r_drv_q;
    logic [31:0] r_ird_q;
    logic [31:0] r_drd_q;

    logic w_gnt_i;
    logic w_gnt_d;
    logic w_idle;
    logic w_hs_i;
    logic w_hs_d;
    logic w_hs;

`ifdef MEM_ARB_RR_EN
    logic r_last_grant_q;
`endif

    mem_arb_grant u_grant (
        .ireq_valid_i (iwIReqValid),
        .dreq_valid_i (iwDReqValid),
`ifdef MEM_ARB_RR_EN
        .last_grant_i (r_last_grant_q),
`endif
        .gnt_i_o      (w_gnt_i),
        .gnt_d_o      (w_gnt_d)
    );

    // Ready is gated by reset so every output reads 0 while iwnRst is low.
    assign w_idle      = (r_state_q == IDLE) & iwnRst;
    assign owIReqReady = w_idle & w_gnt_i;
    assign owDReqReady = w_idle & w_gnt_d;
    assign w_hs_i      = iwIReqValid & owIReqReady;
    assign w_hs_d      = iwDReqValid & owDReqReady;
    assign w_hs        = w_hs_i | w_hs_d;

    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            r_state_q    <= IDLE;
            r_gid_q      <= GNT_I;
            r_store_q    <= 1'b0;
            r_wait_cnt_q <= '0;
            r_mem_en_q   <= 1'b0;
            r_addr_q     <= 32'h0;
            r_wdata_q    <= 32'h0;
            r_wstrb_q    <= 4'h0;
            r_irv_q      <= 1'b0;
            r_drv_q      <= 1'b0;
            r_ird_q      <= 32'h0;
            r_drd_q      <= 32'h0;
        end else begin
            case (r_state_q)
                IDLE: begin
                    if (w_hs) begin
                        r_gid_q    <= w_hs_d ? GNT_D : GNT_I;
                        r_store_q  <= w_hs_d & is_store(iwDWstrb);
                        r_mem_en_q <= 1'b1;
                        r_addr_q   <= w_hs_d ? iwDAddr  : iwIAddr;
                        r_wdata_q  <= w_hs_d ? iwDWdata : 32'h0;
                        r_wstrb_q  <= w_hs_d ? iwDWstrb : 4'h0;
                        r_state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_mem_en_q   <= 1'b0;
                    r_wstrb_q    <= 4'h0;
                    r_wait_cnt_q <= WAIT_LOAD;
                    r_state_q    <= WAIT;
                end
                WAIT: begin
                    if (r_wait_cnt_q == '0) begin
                        if (r_gid_q == GNT_D) begin
                            r_drv_q <= 1'b1;
                            r_drd_q <= r_store_q ? 32'h0 : iwMemRdata;
                        end else begin
                            r_irv_q <= 1'b1;
                            r_ird_q <= iwMemRdata;
                        end
                        r_state_q <= RESP;
                    end else begin
                        r_wait_cnt_q <= r_wait_cnt_q - wait_cnt_t'(1);
                    end
                end
                RESP: begin
                    r_irv_q   <= 1'b0;
                    r_drv_q   <= 1'b0;
                    r_state_q <= IDLE;
                end
                default: begin
                    r_state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            r_last_grant_q <= GNT_I;
        end else if (w_hs) begin
            r_last_grant_q <= w_hs_d ? GNT_D : GNT_I;
        end
    end
`endif

    assign owMemEn      = r_mem_en_q;
    assign owMemAddr    = r_addr_q;
    assign owMemWdata   = r_wdata_q;
    assign owMemWstrb   = r_wstrb_q;
    assign owIRespValid = r_irv_q;
    assign owIRespData  = r_ird_q;
    assign owDRespValid = r_drv_q;
    assign owDRespData  = r_drd_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_port_arbiter
// Brief   : Scoreboard bench for mem_port_arbiter with a transaction-level
//           reference model and a behavioural memory. Honours MEM_ARB_RR_EN.
// Revision: 1.0
// ============================================================================
module tb_mem_port_arbiter;

    localparam int LAT = 4;

    logic        iwClk = 1'b0;
    logic        iwnRst = 1'b0;
    logic        iwIReqValid = 1'b0;
    logic        owIReqReady;
    logic [31:0] iwIAddr = 32'h0;
    logic        owIRespValid;
    logic [31:0] owIRespData;
    logic        iwDReqValid = 1'b0;
    logic        owDReqReady;
    logic [31:0] iwDAddr = 32'h0;
    logic [31:0] iwDWdata = 32'h0;
    logic [3:0]  iwDWstrb = 4'h0;
    logic        owDRespValid;
    logic [31:0] owDRespData;
    logic        owMemEn;
    logic [31:0] owMemAddr;
    logic [31:0] owMemWdata;
    logic [3:0]  owMemWstrb;
    logic [31:0] iwMemRdata = 32'h0;

    mem_port_arbiter #(.pMemLatency(LAT)) dut (
        .iwClk        (iwClk),
        .iwnRst       (iwnRst),
        .iwIReqValid  (iwIReqValid),
        .owIReqReady  (owIReqReady),
        .iwIAddr      (iwIAddr),
        .owIRespValid (owIRespValid),
        .owIRespData  (owIRespData),
        .iwDReqValid  (iwDReqValid),
        .owDReqReady  (owDReqReady),
        .iwDAddr      (iwDAddr),
        .iwDWdata     (iwDWdata),
        .iwDWstrb     (iwDWstrb),
        .owDRespValid (owDRespValid),
        .owDRespData  (owDRespData),
        .owMemEn      (owMemEn),
        .owMemAddr    (owMemAddr),
        .owMemWdata   (owMemWdata),
        .owMemWstrb   (owMemWstrb),
        .iwMemRdata   (iwMemRdata)
    );

    typedef struct {
        int          due;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_exp_t;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        int          due;
    } resp_exp_t;

    mem_exp_t    mem_q[$];
    resp_exp_t   resp_q[$];
    logic [31:0] ref_mem [16];
    logic [31:0] dut_mem [16];
    int          cyc = 0;
    int          next_idle = 0;
    bit          last_d = 1'b0;
    int          rd_cyc = -1;
    logic [31:0] rd_val = 32'h0;
    int          checks = 0;
    int          passes = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rand_addr();
        return ($urandom & 32'hFFFF_FFC0) | 32'($urandom_range(63));
    endfunction

    initial forever #5 iwClk = ~iwClk;

    // Memory read-data driver: valid only in the cycle LAT after owMemEn, noise otherwise.
    initial forever begin
        @(posedge iwClk);
        cyc++;
        #1;
        iwMemRdata = (cyc == rd_cyc) ? rd_val : $urandom;
    end

    always @(negedge iwClk) begin
        bit        gi, gd;
        mem_exp_t  m;
        resp_exp_t r;
        if (!iwnRst) begin
            chk({owIReqReady, owDReqReady, owIRespValid, owDRespValid, owMemEn} == 5'b0 &&
                owIRespData == 32'h0 && owDRespData == 32'h0 && owMemAddr == 32'h0 &&
                owMemWdata == 32'h0 && owMemWstrb == 4'h0,
                "reset_outs", {owMemAddr[15:0], owMemWstrb, 7'b0, owIReqReady, owDReqReady,
                owIRespValid, owDRespValid, owMemEn}, 32'h0);
            mem_q.delete();
            resp_q.delete();
            next_idle = cyc;
            last_d    = 1'b0;
            rd_cyc    = -1;
        end else begin
            gi = 1'b0;
            gd = 1'b0;
            if (cyc >= next_idle) begin
                if (iwIReqValid && iwDReqValid) begin
`ifdef MEM_ARB_RR_EN
                    gd = !last_d;
`else
                    gd = 1'b1;
`endif
                    gi = !gd;
                end else begin
                    gi = iwIReqValid;
                    gd = iwDReqValid;
                end
            end
            chk({owIReqReady, owDReqReady} == {gi, gd}, "ready",
                {30'b0, owIReqReady, owDReqReady}, {30'b0, gi, gd});
            if (gi || gd) begin
                m.due   = cyc + 1;
                m.addr  = gd ? iwDAddr : iwIAddr;
                m.wdata = iwDWdata;
                m.wstrb = gd ? iwDWstrb : 4'h0;
                mem_q.push_back(m);
                r.is_d = gd;
                r.due  = cyc + LAT + 2;
                if (m.wstrb != 4'h0) begin
                    ref_mem[m.addr[5:2]] = merge(ref_mem[m.addr[5:2]], m.wdata, m.wstrb);
                    r.data = 32'h0;
                end else begin
                    r.data = ref_mem[m.addr[5:2]];
                end
                resp_q.push_back(r);
                next_idle = cyc + LAT + 3;
                last_d    = gd;
            end

            if (owMemEn) begin
                if (mem_q.size() == 0) begin
                    chk(1'b0, "mem_unexpected", owMemAddr, 32'h0);
                end else begin
                    m = mem_q.pop_front();
                    chk(cyc == m.due, "mem_cycle", 32'(cyc), 32'(m.due));
                    chk(owMemAddr == m.addr, "mem_addr", owMemAddr, m.addr);
                    chk(owMemWstrb == m.wstrb, "mem_wstrb", {28'b0, owMemWstrb}, {28'b0, m.wstrb});
                    if (m.wstrb != 4'h0)
                        chk(owMemWdata == m.wdata, "mem_wdata", owMemWdata, m.wdata);
                end
                if (owMemWstrb != 4'h0) begin
                    dut_mem[owMemAddr[5:2]] = merge(dut_mem[owMemAddr[5:2]], owMemWdata, owMemWstrb);
                end else begin
                    rd_cyc = cyc + LAT;
                    rd_val = dut_mem[owMemAddr[5:2]];
                end
            end else begin
                chk(owMemWstrb == 4'h0, "wstrb_idle", {28'b0, owMemWstrb}, 32'h0);
            end

            if (owIRespValid || owDRespValid) begin
                if (resp_q.size() == 0) begin
                    chk(1'b0, "resp_unexpected", {30'b0, owIRespValid, owDRespValid}, 32'h0);
                end else begin
                    r = resp_q.pop_front();
                    chk({owIRespValid, owDRespValid} == {!r.is_d, r.is_d}, "resp_who",
                        {30'b0, owIRespValid, owDRespValid}, {30'b0, !r.is_d, r.is_d});
                    chk((r.is_d ? owDRespData : owIRespData) == r.data, "resp_data",
                        r.is_d ? owDRespData : owIRespData, r.data);
                    chk(cyc == r.due, "resp_cycle", 32'(cyc), 32'(r.due));
                end
            end
        end
    end

    task automatic req(input bit d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
        bit done;
        done = 1'b0;
        @(posedge iwClk); #1;
        if (d) begin
            iwDReqValid = 1'b1; iwDAddr = a; iwDWdata = wd; iwDWstrb = st;
        end else begin
            iwIReqValid = 1'b1; iwIAddr = a;
        end
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge iwClk);
            done = d ? owDReqReady : owIReqReady;
        end
        chk(done, "req_handshake", {31'b0, done}, 32'h1);
        @(posedge iwClk); #1;
        if (d) iwDReqValid = 1'b0;
        else   iwIReqValid = 1'b0;
    endtask

    // pi/pd: percent chance an idle requester raises; pw: percent chance a pending one withdraws.
    task automatic run_phase(input int n, input int unsigned pi, input int unsigned pd, input int unsigned pw);
        bit hi, hd, wi, wdr;
        for (int k = 0; k < n; k++) begin
            @(negedge iwClk);
            hi = iwIReqValid && owIReqReady;
            hd = iwDReqValid && owDReqReady;
            @(posedge iwClk); #1;
            wi  = iwIReqValid && !hi && ($urandom_range(99) < pw);
            wdr = iwDReqValid && !hd && ($urandom_range(99) < pw);
            if (hi || wi)  iwIReqValid = 1'b0;
            if (hd || wdr) iwDReqValid = 1'b0;
            if (!iwIReqValid && !wi && $urandom_range(99) < pi) begin
                iwIReqValid = 1'b1;
                iwIAddr     = rand_addr();
            end
            if (!iwDReqValid && !wdr && $urandom_range(99) < pd) begin
                iwDReqValid = 1'b1;
                iwDAddr     = rand_addr();
                iwDWdata    = $urandom;
                iwDWstrb    = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15));
            end
        end
    endtask

    initial begin
        bit drained;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            dut_mem[i] = ref_mem[i];
        end
        ref_mem[4] = 32'hDEADBEEF;
        dut_mem[4] = 32'hDEADBEEF;

        repeat (3) @(posedge iwClk);
        #1 iwnRst = 1'b1;

        req(1'b0, 32'h10, 32'h0, 4'h0);
        req(1'b1, 32'h20, 32'h11223344, 4'b0101);
        req(1'b0, 32'h20, 32'h0, 4'h0);

        // Simultaneous requests from idle.
        @(posedge iwClk); #1;
        iwIReqValid = 1'b1; iwIAddr = 32'h0000_0030;
        iwDReqValid = 1'b1; iwDAddr = 32'h0000_0034; iwDWdata = 32'h0; iwDWstrb = 4'h0;
        run_phase(3 * (LAT + 3), 0, 0, 0);

        // Reset while the store sits in WAIT: the write stays done, no response follows.
        req(1'b1, 32'h24, 32'hCAFEF00D, 4'b1111);
        @(posedge iwClk); #1;
        @(posedge iwClk); #1;
        iwnRst = 1'b0;
        repeat (2) @(posedge iwClk);
        #1 iwnRst = 1'b1;
        req(1'b0, 32'h24, 32'h0, 4'h0);

        run_phase(8 * (LAT + 3), 100, 100, 0);
        run_phase(60, 40, 0, 10);
        run_phase(60, 0, 40, 10);
        run_phase(400, 50, 50, 8);

        @(posedge iwClk); #1;
        iwIReqValid = 1'b0;
        iwDReqValid = 1'b0;
        drained = 1'b0;
        for (int k = 0; k < 100 && !drained; k++) begin
            @(negedge iwClk);
            drained = (resp_q.size() == 0) && (mem_q.size() == 0);
        end
        chk(drained, "drain", 32'(resp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
